// File: rtl/led_alert_ctrl.sv
// Multi-channel LED alert driver: per-channel OFF / SOLID / BLINK / counted BURST modes,
// paced by a shared prescaler tick. All BLINK channels share one phase.
//
// Burst FSM states (per channel):
//   state    | meaning
//   ST_IDLE  | no burst; waiting for a trigger rise while mode==BURST
//   ST_ON    | flash lit for hp ticks
//   ST_OFF   | flash dark for hp ticks; the last OFF window ends the burst
module led_alert_ctrl #(
  parameter int NUM_CH   = 16,
  parameter int TICK_DIV = 10_000_000,
  parameter int PERIOD_W = 8,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [PERIOD_W-1:0]   half_period,
  input  logic [CNT_W-1:0]      burst_len,
  input  logic [NUM_CH-1:0]     trigger,
  output logic [NUM_CH-1:0]     led,
  output logic [NUM_CH-1:0]     burst_busy,
  output logic [NUM_CH-1:0]     burst_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

  logic [PW-1:0]       r_pre;
  logic                w_tick;
  logic [PERIOD_W-1:0] w_hp;
  logic [PERIOD_W-1:0] w_hp_m1;
  logic [PERIOD_W-1:0] r_pcnt;
  logic                r_phase;
  logic [NUM_CH-1:0]   r_trig_q;
  logic [NUM_CH-1:0]   w_rise;

  assign w_tick  = en && (r_pre == PRE_MAX);
  assign w_hp    = (half_period == '0) ? PERIOD_W'(1) : half_period;
  assign w_hp_m1 = w_hp - PERIOD_W'(1);
  assign w_rise  = trigger & ~r_trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end

  // >= rather than == so a lowered half_period wraps on the next tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_pcnt >= w_hp_m1) begin
        r_pcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_pcnt <= r_pcnt + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_trig_q <= '0;
    else        r_trig_q <= trigger;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]          w_mode;
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PERIOD_W-1:0] r_tcnt;
    logic                r_led;
    logic                r_busy;
    logic                r_done;

    assign w_mode        = mode[2*i +: 2];
    assign led[i]        = r_led;
    assign burst_busy[i] = r_busy;
    assign burst_done[i] = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_tcnt  <= '0;
        r_led   <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_done <= 1'b0;
        unique case (w_mode)
          2'b00:   r_led <= 1'b0;
          2'b01:   r_led <= 1'b1;
          2'b10:   r_led <= r_phase;
          default: r_led <= (r_state == ST_ON);
        endcase
        // Leaving BURST aborts silently; no done pulse
        if (w_mode != 2'b11) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end else begin
          unique case (r_state)
            ST_IDLE: begin
              if (w_rise[i] && (burst_len != '0)) begin
                r_cnt   <= burst_len;
                r_tcnt  <= '0;
                r_state <= ST_ON;
                r_busy  <= 1'b1;
              end
            end
            ST_ON: begin
              if (w_tick) begin
                if (r_tcnt >= w_hp_m1) begin
                  r_tcnt  <= '0;
                  r_state <= ST_OFF;
                end else begin
                  r_tcnt <= r_tcnt + PERIOD_W'(1);
                end
              end
            end
            ST_OFF: begin
              if (w_tick) begin
                if (r_tcnt >= w_hp_m1) begin
                  r_tcnt <= '0;
                  if (r_cnt == CNT_W'(1)) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end else begin
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_state <= ST_ON;
                  end
                end else begin
                  r_tcnt <= r_tcnt + PERIOD_W'(1);
                end
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_alert_ctrl.sv
// Scoreboard bench for led_alert_ctrl: a tick-counting reference model pushes expected
// outputs each clock; a negedge monitor pops and compares.
module tb_led_alert_ctrl;

  localparam int NC   = 8;
  localparam int TD   = 2;
  localparam int PWID = 8;
  localparam int CW   = 4;
  localparam int CLK  = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [2*NC-1:0] mode = '0;
  logic [PWID-1:0] half_period = '0;
  logic [CW-1:0]   burst_len = '0;
  logic [NC-1:0]   trigger = '0;
  logic [NC-1:0]   led, burst_busy, burst_done;

  led_alert_ctrl #(.NUM_CH(NC), .TICK_DIV(TD), .PERIOD_W(PWID), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .half_period(half_period),
    .burst_len(burst_len), .trigger(trigger), .led(led), .burst_busy(burst_busy),
    .burst_done(burst_done)
  );

  always #(CLK/2) clk = ~clk;

  typedef struct {
    logic [NC-1:0] led;
    logic [NC-1:0] busy;
    logic [NC-1:0] done;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(string name, logic [NC-1:0] act, logic [NC-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: counts enabled clocks and ticks; blink phase and burst position
  // are derived from tick totals by division rather than by stepping a state machine.
  int m_pre, m_ticks;
  int m_act[NC], m_k[NC], m_len[NC];
  bit m_tq[NC];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pre = 0; m_ticks = 0;
      for (int c = 0; c < NC; c++) begin m_act[c] = 0; m_k[c] = 0; m_len[c] = 0; m_tq[c] = 0; end
    end else begin
      exp_t e;
      int hp;
      bit tick, ph, rise, on_before;
      hp   = (half_period == 0) ? 1 : int'(half_period);
      tick = en && (m_pre == TD-1);
      if (en) m_pre = (m_pre + 1) % TD;
      ph = ((m_ticks / hp) % 2) == 1;
      if (tick) m_ticks++;
      for (int c = 0; c < NC; c++) begin
        rise      = trigger[c] && !m_tq[c];
        m_tq[c]   = trigger[c];
        on_before = (m_act[c] != 0) && ((m_k[c] / hp) % 2 == 0);
        case (mode[2*c +: 2])
          2'd0: e.led[c] = 1'b0;
          2'd1: e.led[c] = 1'b1;
          2'd2: e.led[c] = ph;
          default: e.led[c] = on_before;
        endcase
        e.done[c] = 1'b0;
        if (mode[2*c +: 2] != 2'd3) m_act[c] = 0;
        else if (m_act[c] != 0) begin
          if (tick) begin
            m_k[c]++;
            if (m_k[c] == 2*hp*m_len[c]) begin m_act[c] = 0; e.done[c] = 1'b1; end
          end
        end else if (rise && burst_len != 0) begin
          m_act[c] = 1; m_k[c] = 0; m_len[c] = int'(burst_len);
        end
        e.busy[c] = (m_act[c] != 0);
      end
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("led", led, e.led);
      check("burst_busy", burst_busy, e.busy);
      check("burst_done", burst_done, e.done);
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(int ch, logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic do_reset(int hp);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    mode = '0; trigger = '0; en = 1'b1;
    half_period = PWID'(hp);
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic pulse(int ch);
    trigger[ch] = 1'b1;
    step(1);
    trigger[ch] = 1'b0;
  endtask

  initial begin
    step(1);
    check("reset_led", led, '0);
    check("reset_busy", burst_busy, '0);
    check("reset_done", burst_done, '0);

    // Lockstep blink on channels 0, 3, 7 plus a solid channel
    do_reset(2);
    set_mode(0, 2'b10); set_mode(3, 2'b10); set_mode(7, 2'b10); set_mode(1, 2'b01);
    step(40);

    // Single burst of 3 flashes on channel 5
    do_reset(3);
    burst_len = 4'd3;
    set_mode(5, 2'b11); set_mode(0, 2'b10);
    step(3);
    pulse(5);
    step(45);

    // Re-trigger mid-burst and a long-held trigger: no restart, no queueing
    pulse(5);
    step(10);
    pulse(5);
    step(5);
    trigger[5] = 1'b1;
    step(20);
    trigger[5] = 1'b0;
    step(20);

    // Mode change mid-burst aborts with no done
    pulse(5);
    step(15);
    set_mode(5, 2'b01);
    step(20);

    // Freeze with en=0 during blink and burst, then resume
    set_mode(5, 2'b11);
    step(2);
    pulse(5);
    step(10);
    en = 1'b0;
    step(50);
    en = 1'b1;
    step(40);

    // Async reset mid-burst, checked before any clock edge
    pulse(5);
    step(8);
    @(posedge clk);
    #(CLK/4);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_led", led, '0);
    check("async_rst_busy", burst_busy, '0);
    check("async_rst_done", burst_done, '0);
    @(negedge clk);
    mode = '0; half_period = '0;
    step(1);
    rst_n = 1'b1;
    set_mode(0, 2'b10);
    step(20);

    // Randomized segments across half_period values
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(seg);
      for (int cyc = 0; cyc < 300; cyc++) begin
        if ($urandom_range(0, 15) == 0) mode = 2*NC'($urandom);
        if ($urandom_range(0, 7) == 0)  burst_len = CW'($urandom_range(0, 3));
        en      = ($urandom_range(0, 7) != 0);
        trigger = NC'($urandom) & NC'($urandom);
        step(1);
      end
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
